// File: rtl/inc_share_ctrl.sv
// inc_share_ctrl
//   Round-robin controller that time-shares a single 4-bit +1 incrementer
//   among NREQ independent 4-bit event counters. Each requester posts
//   single-cycle increment pulses, which are latched into a per-requester
//   pending flag. Every cycle, one pending requester is served through the
//   shared incrementer.
//
// Parameters
//   NREQ      number of requesters/counters (2..8)
//
// Ports
//   clk       system clock; all state changes on the rising edge
//   rst       synchronous active-high reset
//   inc_req   per-requester increment pulse (one cycle = one event)
//   clr       per-requester synchronous clear of the counter, pending and
//             overflow flags
//   cnt_flat  counter values; counter i occupies bits [4i+3:4i]
//   gnt       registered one-hot: the requester served at the last edge
//   wrap      registered pulse: the served counter went from 15 to 0
//   ovr       sticky per-requester flag: an event was merged or lost
//   busy      OR of all pending flags
//
// Build option
//   INC_SHARE_SAT_EN  When defined, counters saturate at 15 instead of
//                     wrapping. A saturating service still grants and clears
//                     pending, sets ovr (the event is lost), and wrap stays 0.
module inc_share_ctrl #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   inc_req,
  input  logic [NREQ-1:0]   clr,
  output logic [4*NREQ-1:0] cnt_flat,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   wrap,
  output logic [NREQ-1:0]   ovr,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0][3:0] cnt_q, cnt_d;
  logic [NREQ-1:0]      pend_q, pend_d;
  logic [NREQ-1:0]      gnt_q, gnt_d;
  logic [NREQ-1:0]      wrap_q, wrap_d;
  logic [NREQ-1:0]      ovr_q, ovr_d;
  logic [PW-1:0]        ptr_q, ptr_d;

  logic [NREQ-1:0]      elig;
  logic                 found;
  logic [PW-1:0]        sel;
  logic [3:0]           inc_a;
  logic [3:0]           inc_y;
  logic                 inc_top;

  // A requester being cleared this cycle is masked out of arbitration, so the
  // scan moves on to the next eligible requester.
  assign elig = pend_q & ~clr;

  // Round-robin scan starting at ptr_q. The first eligible index wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && elig[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        sel   = PW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  // The single shared incrementer, fed through a mux on the granted index.
  always_comb begin
    inc_a   = cnt_q[sel];
    inc_top = (inc_a == 4'hF);
`ifdef INC_SHARE_SAT_EN
    inc_y   = inc_top ? inc_a : inc_a + 4'd1;
`else
    inc_y   = inc_a + 4'd1;
`endif
  end

  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    gnt_d  = '0;
    wrap_d = '0;
    ptr_d  = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (clr[i]) begin
        cnt_d[i]  = 4'd0;
        pend_d[i] = 1'b0;
        ovr_d[i]  = 1'b0;
      end else begin
        if (found && (sel == PW'(i))) begin
          cnt_d[i]  = inc_y;
          pend_d[i] = 1'b0;
          gnt_d[i]  = 1'b1;
`ifdef INC_SHARE_SAT_EN
          if (inc_top) ovr_d[i] = 1'b1;
`else
          wrap_d[i] = inc_top;
`endif
        end else if (inc_req[i] && pend_q[i]) begin
          // A second event arrived before the first was served: they merge.
          ovr_d[i] = 1'b1;
        end
        // A new event arriving during service stays pending.
        if (inc_req[i]) pend_d[i] = 1'b1;
      end
    end
    if (found) begin
      ptr_d = (sel == PW'(NREQ - 1)) ? '0 : sel + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pend_q <= '0;
      gnt_q  <= '0;
      wrap_q <= '0;
      ovr_q  <= '0;
      ptr_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      gnt_q  <= gnt_d;
      wrap_q <= wrap_d;
      ovr_q  <= ovr_d;
      ptr_q  <= ptr_d;
    end
  end

  assign cnt_flat = cnt_q;
  assign gnt      = gnt_q;
  assign wrap     = wrap_q;
  assign ovr      = ovr_q;
  assign busy     = |pend_q;

endmodule

// File: tb/tb_inc_share_ctrl.sv
// Testbench for inc_share_ctrl (NREQ=4). Directed scenarios followed by
// random traffic, all checked every cycle against a behavioural model.
module tb_inc_share_ctrl;

  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   inc_req;
  logic [N-1:0]   clr;
  logic [4*N-1:0] cnt_flat;
  logic [N-1:0]   gnt;
  logic [N-1:0]   wrap;
  logic [N-1:0]   ovr;
  logic           busy;

  int totalChecks;
  int badChecks;

  // Reference state
  int       mCnt [N];
  bit       mPend [N];
  bit       mOvr [N];
  bit [N-1:0] mGnt;
  bit [N-1:0] mWrap;
  int       mPtr;

  inc_share_ctrl #(.NREQ(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .inc_req  (inc_req),
    .clr      (clr),
    .cnt_flat (cnt_flat),
    .gnt      (gnt),
    .wrap     (wrap),
    .ovr      (ovr),
    .busy     (busy)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s at %0t: got %0h, want %0h", tag, $time,
               observed, expected);
    end
  endtask

  // Advance the model by one rising edge
  task automatic modelStep(input bit r, input bit [N-1:0] req, input bit [N-1:0] c);
    int chosen;
    int j;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        mCnt[i] = 0; mPend[i] = 0; mOvr[i] = 0;
      end
      mGnt = '0; mWrap = '0; mPtr = 0;
      return;
    end
    chosen = -1;
    for (int k = 0; k < N; k++) begin
      j = (mPtr + k) % N;
      if (chosen < 0 && mPend[j] && !c[j]) chosen = j;
    end
    mGnt = '0; mWrap = '0;
    for (int i = 0; i < N; i++) begin
      if (c[i]) begin
        mCnt[i] = 0; mPend[i] = 0; mOvr[i] = 0;
      end else if (i == chosen) begin
        mGnt[i] = 1;
`ifdef INC_SHARE_SAT_EN
        if (mCnt[i] == 15) mOvr[i] = 1;
        else mCnt[i] = mCnt[i] + 1;
`else
        mCnt[i] = (mCnt[i] + 1) % 16;
        if (mCnt[i] == 0) mWrap[i] = 1;
`endif
        mPend[i] = req[i];
      end else begin
        if (req[i] && mPend[i]) mOvr[i] = 1;
        if (req[i]) mPend[i] = 1;
      end
    end
    if (chosen >= 0) mPtr = (chosen + 1) % N;
  endtask

  // Drive one cycle of inputs, clock it, update the model, check outputs
  task automatic applyStimulus(input bit r, input bit [N-1:0] req, input bit [N-1:0] c);
    logic [4*N-1:0] expCnt;
    logic [N-1:0]   expOvr;
    logic           expBusy;
    rst = r; inc_req = req; clr = c;
    @(posedge clk);
    modelStep(r, req, c);
    #1;
    expBusy = 1'b0;
    for (int i = 0; i < N; i++) begin
      expCnt[4*i +: 4] = 4'(mCnt[i]);
      expOvr[i]        = mOvr[i];
      expBusy          = expBusy | mPend[i];
    end
    checkOutput("cnt",  32'(cnt_flat), 32'(expCnt));
    checkOutput("gnt",  32'(gnt),      32'(mGnt));
    checkOutput("wrap", 32'(wrap),     32'(mWrap));
    checkOutput("ovr",  32'(ovr),      32'(expOvr));
    checkOutput("busy", 32'(busy),     32'(expBusy));
  endtask

  initial begin
    bit [N-1:0] rq;
    bit [N-1:0] cl;
    bit         rs;
    totalChecks = 0;
    badChecks   = 0;
    rst = 1'b1; inc_req = '0; clr = '0;
    for (int i = 0; i < N; i++) begin
      mCnt[i] = 0; mPend[i] = 0; mOvr[i] = 0;
    end
    mGnt = '0; mWrap = '0; mPtr = 0;
    #2;

    // Reset held two cycles with all requests asserted
    applyStimulus(1, 4'b1111, 4'b0000);
    applyStimulus(1, 4'b1111, 4'b0000);
    applyStimulus(0, 4'b0000, 4'b0000);

    // Single event on requester 2
    applyStimulus(0, 4'b0100, 4'b0000);
    repeat (3) applyStimulus(0, 4'b0000, 4'b0000);

    // Round-robin sweep from reset
    applyStimulus(1, 4'b0000, 4'b0000);
    applyStimulus(0, 4'b1111, 4'b0000);
    repeat (5) applyStimulus(0, 4'b0000, 4'b0000);

    // Sixteen separate events to requester 1 (wrap or saturate)
    applyStimulus(1, 4'b0000, 4'b0000);
    repeat (16) begin
      applyStimulus(0, 4'b0010, 4'b0000);
      applyStimulus(0, 4'b0000, 4'b0000);
    end
    applyStimulus(0, 4'b0000, 4'b0000);

    // Merge: second event on requester 1 while still pending
    applyStimulus(1, 4'b0000, 4'b0000);
    applyStimulus(0, 4'b0011, 4'b0000);
    applyStimulus(0, 4'b0010, 4'b0000);
    repeat (3) applyStimulus(0, 4'b0000, 4'b0000);

    // Clear precedence: move ptr to 3, pend 3 and 0, then clear 3 with a request
    applyStimulus(1, 4'b0000, 4'b0000);
    applyStimulus(0, 4'b0100, 4'b0000);
    applyStimulus(0, 4'b0000, 4'b0000);
    applyStimulus(0, 4'b1001, 4'b0000);
    applyStimulus(0, 4'b1000, 4'b1000);
    repeat (3) applyStimulus(0, 4'b0000, 4'b0000);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rs = ($urandom_range(0, 79) == 0);
      rq = N'($urandom);
      if ($urandom_range(0, 2) == 0) rq = '0;
      cl = '0;
      for (int i = 0; i < N; i++) cl[i] = ($urandom_range(0, 11) == 0);
      applyStimulus(rs, rq, cl);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
